// File: rtl/controlador_lote_pkg.sv
// Shared state codes and default sizing for the conveyor batch sequencer.
// State encoding is visible on the state port, so the codes are fixed.
package controlador_lote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWAP  = 2'd2,
    ST_EMERG = 2'd3
  } estado_t;

  localparam int BATCH_SIZE_DEF   = 10;
  localparam int IDLE_TIMEOUT_DEF = 5;
  localparam int ITEM_W_DEF       = 4;
  localparam int BATCH_W_DEF      = 8;
  localparam int TMO_W_DEF        = 3;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: pulse is combinational from din and the registered previous sample.
// Zero latency on the pulse; the sample register updates every cycle, no backpressure.
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse = din & ~prev_q;

endmodule

// File: rtl/controlador_lote_esteira.sv
// Conveyor batch sequencer: runs the belt, counts items into batches, halts for box swap/emergency.
// Every output is registered and reflects the inputs sampled on the previous clock edge.
module controlador_lote_esteira
  import controlador_lote_pkg::*;
#(
  parameter int BATCH_SIZE   = BATCH_SIZE_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter int ITEM_W       = ITEM_W_DEF,
  parameter int BATCH_W      = BATCH_W_DEF,
  parameter int TMO_W        = TMO_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               perigo,
  input  logic               ack,
  input  logic               sensor,
  input  logic               box_ready,
  output logic               motor_en,
  output logic               LED_vd,
  output logic               LED_vm,
  output logic               starve,
  output logic               batch_done,
  output logic [ITEM_W-1:0]  item_count,
  output logic [BATCH_W-1:0] batch_count,
  output logic [1:0]         state
);

  localparam logic [ITEM_W-1:0] ITEM_FULL = ITEM_W'(BATCH_SIZE);
  localparam logic [ITEM_W-1:0] ITEM_LAST = ITEM_W'(BATCH_SIZE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(IDLE_TIMEOUT - 1);

  estado_t            state_q, state_d;
  logic [ITEM_W-1:0]  item_q, item_d;
  logic [BATCH_W-1:0] batch_q, batch_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               starve_q, starve_d;
  logic               done_q, done_d;
  logic               motor_q, motor_d;
  logic               vd_q, vd_d;
  logic               vm_q, vm_d;
  logic               item_evt;

  detector_borda u_borda (
    .clk   (clk),
    .rst   (rst),
    .din   (sensor),
    .pulse (item_evt)
  );

  always_comb begin
    state_d  = state_q;
    item_d   = item_q;
    batch_d  = batch_q;
    tmo_d    = tmo_q;
    starve_d = starve_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (perigo) begin
          state_d = ST_EMERG;
        end else if (start && !stop) begin
          starve_d = 1'b0;
          tmo_d    = '0;
          // A batch interrupted during the swap resumes waiting for the new box
          state_d  = (item_q == ITEM_FULL) ? ST_SWAP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (perigo) begin
          state_d = ST_EMERG;
        end else if (stop) begin
          state_d = ST_IDLE;
        end else if (item_evt) begin
          item_d = item_q + 1'b1;
          tmo_d  = '0;
          if (item_q == ITEM_LAST) begin
            state_d = ST_SWAP;
            done_d  = 1'b1;
            if (batch_q != '1) begin
              batch_d = batch_q + 1'b1;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d  = ST_IDLE;
          starve_d = 1'b1;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SWAP: begin
        if (perigo) begin
          state_d = ST_EMERG;
        end else if (stop) begin
          state_d = ST_IDLE;
        end else if (box_ready) begin
          state_d = ST_RUN;
          item_d  = '0;
          tmo_d   = '0;
        end
      end
      default: begin
        if (ack && !perigo) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    motor_d = (state_d == ST_RUN);
    vd_d    = (state_d == ST_RUN);
    vm_d    = (state_d == ST_EMERG) || ((state_d == ST_SWAP) && !vm_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      item_q   <= '0;
      batch_q  <= '0;
      tmo_q    <= '0;
      starve_q <= 1'b0;
      done_q   <= 1'b0;
      motor_q  <= 1'b0;
      vd_q     <= 1'b0;
      vm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      batch_q  <= batch_d;
      tmo_q    <= tmo_d;
      starve_q <= starve_d;
      done_q   <= done_d;
      motor_q  <= motor_d;
      vd_q     <= vd_d;
      vm_q     <= vm_d;
    end
  end

  assign motor_en    = motor_q;
  assign LED_vd      = vd_q;
  assign LED_vm      = vm_q;
  assign starve      = starve_q;
  assign batch_done  = done_q;
  assign item_count  = item_q;
  assign batch_count = batch_q;
  assign state       = state_q;

endmodule

// File: tb/tb_controlador_lote_esteira.sv
// Bench for the conveyor batch sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_controlador_lote_esteira;

  localparam int BS  = 10;
  localparam int TMO = 5;
  localparam int IW  = 4;
  localparam int BW  = 2;
  localparam int TW  = 3;
  localparam int BMAX = (1 << BW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, perigo = 1'b0, ack = 1'b0;
  logic sensor = 1'b0, box_ready = 1'b0;
  logic motor_en, LED_vd, LED_vm, starve, batch_done;
  logic [IW-1:0] item_count;
  logic [BW-1:0] batch_count;
  logic [1:0]    state;

  always #5 clk = ~clk;

  controlador_lote_esteira #(
    .BATCH_SIZE(BS), .IDLE_TIMEOUT(TMO), .ITEM_W(IW), .BATCH_W(BW), .TMO_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .perigo(perigo), .ack(ack),
    .sensor(sensor), .box_ready(box_ready), .motor_en(motor_en), .LED_vd(LED_vd),
    .LED_vm(LED_vm), .starve(starve), .batch_done(batch_done),
    .item_count(item_count), .batch_count(batch_count), .state(state)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 waiting for box, 3 emergency
  int m_mode = 0, m_items = 0, m_batches = 0, m_quiet = 0;
  bit m_starve = 0, m_done = 0, m_blink = 0, m_prev = 0;

  always @(posedge clk or negedge rst) begin
    bit evt;
    if (!rst) begin
      m_mode = 0; m_items = 0; m_batches = 0; m_quiet = 0;
      m_starve = 0; m_done = 0; m_blink = 0; m_prev = 0;
    end else begin
      evt = sensor && !m_prev;
      m_prev = sensor;
      m_done = 0;
      if (m_mode == 3) begin
        if (ack && !perigo) m_mode = 0;
      end else if (perigo) begin
        m_mode = 3;
      end else if (m_mode == 0) begin
        if (start && !stop) begin
          m_starve = 0;
          m_quiet = 0;
          m_mode = (m_items == BS) ? 2 : 1;
        end
      end else if (stop) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (evt) begin
          m_items++;
          m_quiet = 0;
          if (m_items == BS) begin
            m_mode = 2;
            m_done = 1;
            m_batches = (m_batches < BMAX) ? m_batches + 1 : BMAX;
          end
        end else begin
          m_quiet++;
          if (m_quiet == TMO) begin
            m_mode = 0;
            m_starve = 1;
            m_quiet = 0;
          end
        end
      end else if (box_ready) begin
        m_mode = 1;
        m_items = 0;
        m_quiet = 0;
      end
      m_blink = (m_mode == 3) ? 1'b1 : (m_mode == 2) ? !m_blink : 1'b0;
    end
  end

  always @(negedge clk) begin
    check("state", state, m_mode);
    check("motor_en", motor_en, m_mode == 1);
    check("LED_vd", LED_vd, m_mode == 1);
    check("LED_vm", LED_vm, m_blink);
    check("starve", starve, m_starve);
    check("batch_done", batch_done, m_done);
    check("item_count", item_count, m_items);
    check("batch_count", batch_count, m_batches);
  end

  task automatic item_edge();
    sensor = 1'b1;
    @(negedge clk);
    sensor = 1'b0;
    @(negedge clk);
  endtask

  task automatic full_batch_and_swap();
    for (int i = 0; i < BS; i++) item_edge();
    box_ready = 1'b1;
    @(negedge clk);
    box_ready = 1'b0;
  endtask

  initial begin
    // Reset held with start high and sensor toggling
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      sensor = ~sensor;
    end
    check("lit_rst_state", state, 0);
    check("lit_rst_motor", motor_en, 0);
    check("lit_rst_items", item_count, 0);
    start = 1'b0;
    sensor = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("lit_idle_after_rst", state, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lit_run_after_start", state, 1);
    check("lit_run_motor", motor_en, 1);

    // One full batch, item count stepping 1..10
    for (int i = 1; i <= BS; i++) begin
      sensor = 1'b1;
      @(negedge clk);
      sensor = 1'b0;
      check("lit_item_step", item_count, i);
      if (i == BS) begin
        check("lit_swap_state", state, 2);
        check("lit_batch_done", batch_done, 1);
      end
      @(negedge clk);
    end
    check("lit_done_cleared", batch_done, 0);
    check("lit_swap_motor", motor_en, 0);
    box_ready = 1'b1;
    @(negedge clk);
    box_ready = 1'b0;
    check("lit_box_run", state, 1);
    check("lit_box_items", item_count, 0);
    check("lit_box_batches", batch_count, 1);

    // Starvation: the fifth quiet running cycle stops the belt
    repeat (4) @(negedge clk);
    check("lit_still_run", state, 1);
    @(negedge clk);
    check("lit_starve_state", state, 0);
    check("lit_starve_flag", starve, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lit_restart", state, 1);
    check("lit_starve_clr", starve, 0);

    // Emergency with a simultaneous item edge
    item_edge();
    check("lit_one_item", item_count, 1);
    perigo = 1'b1;
    sensor = 1'b1;
    @(negedge clk);
    sensor = 1'b0;
    check("lit_emerg", state, 3);
    check("lit_emerg_items", item_count, 1);
    ack = 1'b1;
    @(negedge clk);
    check("lit_ack_ignored", state, 3);
    perigo = 1'b0;
    ack = 1'b0;
    @(negedge clk);
    check("lit_emerg_hold", state, 3);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("lit_emerg_exit", state, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lit_emerg_restart", state, 1);

    // Stop overrides start; stop during swap resumes into swap
    stop = 1'b1;
    @(negedge clk);
    check("lit_stop_idle", state, 0);
    start = 1'b1;
    @(negedge clk);
    check("lit_stop_start_idle", state, 0);
    stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("lit_run_again", state, 1);
    for (int i = 0; i < BS - 1; i++) item_edge();
    check("lit_swap2", state, 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("lit_swap_stop", state, 0);
    check("lit_swap_stop_items", item_count, BS);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lit_resume_swap", state, 2);
    box_ready = 1'b1;
    @(negedge clk);
    box_ready = 1'b0;
    check("lit_batches2", batch_count, 2);

    // Batch counter saturation with a 2-bit counter
    repeat (3) full_batch_and_swap();
    check("lit_batch_sat", batch_count, 3);

    // Random traffic, including rare mid-run resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 99) < 25);
      stop      = ($urandom_range(0, 99) < 4);
      perigo    = ($urandom_range(0, 99) < 3);
      ack       = ($urandom_range(0, 99) < 20);
      box_ready = ($urandom_range(0, 99) < 15);
      sensor    = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 499) != 0);
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
